// File: rtl/lf_pkg.sv
// Shared types and helpers for the digital PLL loop filter.
//   lf_state_t   : lock-detect gear (acquisition / tracking)
//   calc_t       : wide signed type used for all datapath arithmetic,
//                  large enough that no intermediate result can overflow
//   sat_signed   : clamp to the range of a w-bit signed number
//   sat_unsigned : clamp to the range of a w-bit unsigned number
//   abs_err      : magnitude of a (sign-extended) error sample
package lf_pkg;

    typedef enum logic [0:0] {
        LF_ACQ = 1'b0,
        LF_TRK = 1'b1
    } lf_state_t;

    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic calc_t sat_signed(input calc_t v, input int w);
        calc_t hi;
        calc_t lo;
        hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo = -(calc_t'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic calc_t sat_unsigned(input calc_t v, input int w);
        calc_t hi;
        hi = (calc_t'(1) <<< w) - calc_t'(1);
        if (v > hi) return hi;
        if (v < calc_t'(0)) return calc_t'(0);
        return v;
    endfunction

    // Operand is already widened, so negating the most negative input
    // sample cannot overflow.
    function automatic calc_t abs_err(input calc_t v);
        return (v < calc_t'(0)) ? -v : v;
    endfunction

endpackage

// File: rtl/lf_lock_det.sv
// Lock detector: counts consecutive in-band error samples while in
// acquisition and shifts to tracking once LOCK_CNT are seen; drops back to
// acquisition on a large error or on force_acq.
//   clk, reset  : clock, synchronous active-high reset
//   i_valid     : error sample qualifier
//   i_err       : signed error sample
//   i_hold      : freeze counter and state (force still acts)
//   i_force_acq : return to acquisition, clear counter
//   o_state     : current gear (selects gains in the datapath)
//   o_locked    : high while tracking
module lf_lock_det
    import lf_pkg::*;
#(
    parameter int IN_W       = 4,
    parameter int LOCK_THR   = 1,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_THR = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic signed [IN_W-1:0] i_err,
    input  logic                   i_hold,
    input  logic                   i_force_acq,
    output lf_state_t              o_state,
    output logic                   o_locked
);

    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    lf_state_t        r_state;
    lf_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    calc_t            w_abs;

    assign w_abs = abs_err(calc_t'(i_err));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LF_ACQ;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (i_force_acq) begin
            // Wins over any lock transition the same sample would cause.
            w_state_next = LF_ACQ;
            w_cnt_next   = '0;
        end else if (i_valid && !i_hold) begin
            case (r_state)
                LF_ACQ: begin
                    if (w_abs <= calc_t'(LOCK_THR)) begin
                        if (r_cnt == CNT_W'(LOCK_CNT - 1)) begin
                            w_state_next = LF_TRK;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cnt_next = '0;
                    end
                end
                LF_TRK: begin
                    if (w_abs > calc_t'(UNLOCK_THR)) begin
                        w_state_next = LF_ACQ;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    w_state_next = LF_ACQ;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign o_state  = r_state;
    assign o_locked = (r_state == LF_TRK);

endmodule

// File: rtl/digital_lf_gear.sv
// Gear-shifting PI loop filter for the digital PLL. Turns a signed timing
// error into an unsigned DCO control word centred on INIT. The integrator
// carries FRAC fractional bits and has Ki applied on entry, so switching
// gains between acquisition and tracking never steps the output.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : qualifies in
//   in         : signed timing error
//   hold       : freeze integrator and lock counter
//   force_acq  : return to acquisition gains
//   out        : control word (one-cycle latency)
//   out_valid  : pulses one cycle after each valid sample
//   locked     : high in tracking
//   sat        : out was clamped on the last update
module digital_lf_gear
    import lf_pkg::*;
#(
    parameter int IN_W       = 4,
    parameter int OUT_W      = 13,
    parameter int ACC_W      = 20,
    parameter int FRAC       = 4,
    parameter int INIT       = 4096,
    parameter int KP_ACQ     = 32,
    parameter int KI_ACQ     = 16,
    parameter int KP_TRK     = 8,
    parameter int KI_TRK     = 2,
    parameter int LOCK_THR   = 1,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_THR = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] in,
    input  logic                   hold,
    input  logic                   force_acq,
    output logic [OUT_W-1:0]       out,
    output logic                   out_valid,
    output logic                   locked,
    output logic                   sat
);

    logic signed [ACC_W-1:0] r_acc;
    logic [OUT_W-1:0]        r_out;
    logic                    r_out_valid;
    logic                    r_sat;

    lf_state_t w_state;
    calc_t     w_in;
    calc_t     w_kp;
    calc_t     w_ki;
    calc_t     w_out_raw;
    calc_t     w_out_sat;
    calc_t     w_acc_raw;
    calc_t     w_acc_sat;

    lf_lock_det #(
        .IN_W       (IN_W),
        .LOCK_THR   (LOCK_THR),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_THR (UNLOCK_THR)
    ) u_lock_det (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (in_valid),
        .i_err       (in),
        .i_hold      (hold),
        .i_force_acq (force_acq),
        .o_state     (w_state),
        .o_locked    (locked)
    );

    // Gains follow the registered state, i.e. the gear in force during the
    // sample's own cycle.
    assign w_in = calc_t'(in);
    assign w_kp = (w_state == LF_TRK) ? calc_t'(KP_TRK) : calc_t'(KP_ACQ);
    assign w_ki = (w_state == LF_TRK) ? calc_t'(KI_TRK) : calc_t'(KI_ACQ);

    // Output uses the pre-update integrator; its fraction is dropped by an
    // arithmetic shift (floor toward minus infinity).
    assign w_out_raw = calc_t'(INIT) + w_kp * w_in + (calc_t'(r_acc) >>> FRAC);
    assign w_out_sat = sat_unsigned(w_out_raw, OUT_W);
    assign w_acc_raw = calc_t'(r_acc) + w_ki * w_in;
    assign w_acc_sat = sat_signed(w_acc_raw, ACC_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= OUT_W'(INIT);
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else if (in_valid) begin
            r_out       <= OUT_W'(w_out_sat);
            r_out_valid <= 1'b1;
            r_sat       <= (w_out_sat != w_out_raw);
            if (!hold) begin
                r_acc <= ACC_W'(w_acc_sat);
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign sat       = r_sat;

endmodule

// File: tb/tb_digital_lf_gear.sv
module tb_digital_lf_gear;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic signed [3:0] in_s;
    logic              hold;
    logic              force_acq;
    logic [12:0]       out;
    logic              out_valid;
    logic              locked;
    logic              sat;

    int n_cmp = 0;
    int n_err = 0;
    int acc_m;
    int raw;
    int exp_out;

    always #5 clk = ~clk;

    digital_lf_gear dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in_s),
        .hold      (hold),
        .force_acq (force_acq),
        .out       (out),
        .out_valid (out_valid),
        .locked    (locked),
        .sat       (sat)
    );

    typedef struct {
        logic              v;
        logic signed [3:0] x;
        logic              h;
        logic              f;
        int                e_out;
        logic              e_ov;
        logic              e_lk;
        logic              e_sat;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the capturing edge.
    task automatic step(input logic v, input logic signed [3:0] x, input logic h, input logic f);
        in_valid  = v;
        in_s      = x;
        hold      = h;
        force_acq = f;
        @(posedge clk);
        #1;
        $display("t=%0t v=%0b in=%0d hold=%0b fa=%0b -> out=%0d ov=%0b lk=%0b sat=%0b",
                 $time, v, x, h, f, out, out_valid, locked, sat);
        in_valid  = 1'b0;
        hold      = 1'b0;
        force_acq = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_s      = 4'sd0;
        hold      = 1'b0;
        force_acq = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out", int'(out), 4096);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_lk", int'(locked), 0);
        chk("rst_sat", int'(sat), 0);
        reset = 1'b0;
    endtask

    task automatic lock_up(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 4'sd0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'sd1,     1'b0, 1'b0, 4128, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'sd0,     1'b0, 1'b0, 4097, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'sd0,     1'b0, 1'b0, 4097, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 4'sb1111,  1'b0, 1'b0, 4065, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 4'sd0,     1'b0, 1'b0, 4096, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 4'sb1000,  1'b1, 1'b0, 3840, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 4'sd0,     1'b0, 1'b0, 4096, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 4'sd3,     1'b1, 1'b0, 4192, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 4'sd0,     1'b0, 1'b0, 4096, 1'b1, 1'b0, 1'b0};

        // Basic response, latency, out_valid pulse, hold.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].x, tbl[i].h, tbl[i].f);
            chk("tbl_out", int'(out), tbl[i].e_out);
            chk("tbl_ov", int'(out_valid), int'(tbl[i].e_ov));
            chk("tbl_lk", int'(locked), int'(tbl[i].e_lk));
            chk("tbl_sat", int'(sat), int'(tbl[i].e_sat));
        end

        // Saturation upward: acc +112 per sample to the integrator ceiling.
        do_reset();
        acc_m = 0;
        for (int n = 0; n < 4700; n++) begin
            raw     = 4096 + 224 + (acc_m >>> 4);
            exp_out = (raw > 8191) ? 8191 : raw;
            step(1'b1, 4'sd7, 1'b0, 1'b0);
            chk("satup_out", int'(out), exp_out);
            chk("satup_sat", int'(sat), (raw > 8191) ? 1 : 0);
            acc_m = (acc_m + 112 > 524287) ? 524287 : acc_m + 112;
        end
        step(1'b0, 4'sd0, 1'b0, 1'b0);
        chk("sathold_sat", int'(sat), 1);
        chk("sathold_ov", int'(out_valid), 0);
        chk("sathold_out", int'(out), 8191);
        // Pull back out of the clamp with the most negative error.
        for (int n = 0; n < 3600; n++) begin
            raw     = 4096 - 256 + (acc_m >>> 4);
            exp_out = (raw > 8191) ? 8191 : ((raw < 0) ? 0 : raw);
            step(1'b1, 4'sb1000, 1'b0, 1'b0);
            chk("satdn_out", int'(out), exp_out);
            chk("satdn_sat", int'(sat), (raw > 8191 || raw < 0) ? 1 : 0);
            acc_m = (acc_m - 128 < -524288) ? -524288 : acc_m - 128;
        end

        // Lock with invalid gaps, then tracking gains, then unlock.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'sd0, 1'b0, 1'b0);
            chk("lock_out", int'(out), 4096);
            chk("lock_lk", int'(locked), (i == 15) ? 1 : 0);
            step(1'b0, 4'sd0, 1'b0, 1'b0);
            chk("gap_ov", int'(out_valid), 0);
            chk("gap_lk", int'(locked), (i == 15) ? 1 : 0);
        end
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 4'sd1, 1'b0, 1'b0);
            chk("trk_out", int'(out), 4104);
            chk("trk_lk", int'(locked), 1);
        end
        step(1'b1, 4'sd0, 1'b0, 1'b0);
        chk("trk_acc_out", int'(out), 4097);
        step(1'b1, 4'sd5, 1'b0, 1'b0);
        chk("unlock_out", int'(out), 4137);
        chk("unlock_lk", int'(locked), 0);
        step(1'b1, 4'sd0, 1'b0, 1'b0);
        chk("unlock_acc_out", int'(out), 4097);

        // An out-of-band sample clears the counter.
        do_reset();
        lock_up(15);
        chk("clr15_lk", int'(locked), 0);
        step(1'b1, 4'sd2, 1'b0, 1'b0);
        chk("clr_out", int'(out), 4160);
        chk("clr_lk", int'(locked), 0);
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 4'sd0, 1'b0, 1'b0);
            chk("clr_after_out", int'(out), 4098);
            chk("clr_after_lk", int'(locked), 0);
        end
        step(1'b1, 4'sd0, 1'b0, 1'b0);
        chk("clr_relock_lk", int'(locked), 1);

        // Hold freezes integrator and counter but not the output.
        do_reset();
        lock_up(15);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'sd3, 1'b1, 1'b0);
            chk("hold_out", int'(out), 4192);
            chk("hold_lk", int'(locked), 0);
        end
        step(1'b1, 4'sd0, 1'b0, 1'b0);
        chk("hold_after_out", int'(out), 4096);
        chk("hold_after_lk", int'(locked), 1);

        // force_acq in tracking: sample uses tracking gains, state drops.
        do_reset();
        lock_up(16);
        chk("fa_pre_lk", int'(locked), 1);
        step(1'b1, 4'sd0, 1'b0, 1'b1);
        chk("fa0_out", int'(out), 4096);
        chk("fa0_lk", int'(locked), 0);
        lock_up(16);
        chk("fa_relock_lk", int'(locked), 1);
        step(1'b1, 4'sd1, 1'b0, 1'b1);
        chk("fa1_out", int'(out), 4104);
        chk("fa1_lk", int'(locked), 0);
        step(1'b1, 4'sd1, 1'b0, 1'b0);
        chk("fa_acq_out", int'(out), 4128);
        step(1'b1, 4'sd0, 1'b0, 1'b0);
        chk("fa_acc_out", int'(out), 4097);

        // force_acq beats the lock transition on the 16th sample.
        do_reset();
        lock_up(15);
        step(1'b1, 4'sd0, 1'b0, 1'b1);
        chk("fa_prio_lk", int'(locked), 0);
        step(1'b1, 4'sd0, 1'b0, 1'b0);
        chk("fa_prio2_lk", int'(locked), 0);

        // Most negative input must count as a large error in tracking.
        do_reset();
        lock_up(16);
        step(1'b1, 4'sb1000, 1'b0, 1'b0);
        chk("neg8_out", int'(out), 4032);
        chk("neg8_lk", int'(locked), 0);

        // Reset mid-stream discards the in-flight sample.
        do_reset();
        lock_up(16);
        step(1'b1, 4'sd3, 1'b0, 1'b0);
        chk("mr_a_out", int'(out), 4120);
        step(1'b1, 4'sd3, 1'b0, 1'b0);
        step(1'b1, 4'sd3, 1'b0, 1'b0);
        step(1'b1, 4'sd3, 1'b0, 1'b0);
        chk("mr_b_out", int'(out), 4121);
        chk("mr_b_lk", int'(locked), 1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_s     = 4'sd3;
        @(posedge clk);
        #1;
        chk("mr_out", int'(out), 4096);
        chk("mr_ov", int'(out_valid), 0);
        chk("mr_lk", int'(locked), 0);
        chk("mr_sat", int'(sat), 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        step(1'b1, 4'sd0, 1'b0, 1'b0);
        chk("mr_after_out", int'(out), 4096);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/digital_lf_gear.md
Name: digital_lf_gear

Overview:
Parametrised next-generation PI loop filter for the digital PLL. It takes a signed timing-error sample and produces an unsigned DCO control word. It adds configurable widths, a fractional integrator, two gain sets switched by a lock-detect FSM (acquisition/tracking gear shift), an integrator hold, and saturation. It sits between the phase detector/TDC and the DCO control input.

Parameters:
IN_W, 4, error input width (signed)
OUT_W, 13, control output width (unsigned)
ACC_W, 20, integrator width (signed, FRAC fractional bits)
FRAC, 4, integrator fractional bits
INIT, 4096, output centre / reset value
KP_ACQ, 32, proportional gain, ACQ state
KI_ACQ, 16, integral gain, ACQ state
KP_TRK, 8, proportional gain, TRK state
KI_TRK, 2, integral gain, TRK state
LOCK_THR, 1, |in| <= this counts toward lock
LOCK_CNT, 16, consecutive in-band samples needed to lock
UNLOCK_THR, 4, |in| > this in TRK forces ACQ

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  qualifies in
in  in  IN_W  signed timing error
hold  in  1  freeze integrator and lock counter
force_acq  in  1  return to ACQ and clear lock counter
out  out  OUT_W  control word
out_valid  out  1  pulses one cycle after each valid sample
locked  out  1  high in TRK
sat  out  1  out clamped on the last update

Behaviour:
- Reset (synchronous, priority over all inputs): out=INIT, acc=0, state=ACQ, lock counter=0, out_valid=0, locked=0, sat=0. A reset mid-operation discards the in-flight sample.
- Gain set is chosen by the state in the sample's cycle, before any transition that cycle causes.
- On each in_valid cycle:
  - out <= clamp(INIT + Kp*in + (acc >>> FRAC), 0, 2^OUT_W-1), using the pre-update acc.
  - acc <= clamp(acc + Ki*in, -2^(ACC_W-1), 2^(ACC_W-1)-1), skipped when hold=1.
  - out_valid <= 1; sat <= 1 iff clamping occurred on out.
- Latency: one cycle. When in_valid=0: out holds, out_valid=0, sat holds.
- Internal arithmetic: full-precision signed, wide enough that no intermediate overflow occurs; clamping happens only at the final assignment.
- Gear shifting is bumpless: the integral term carries no gain at readout, so changing Ki does not step out.
- hold=1: out still updates with the proportional and current integral terms. The lock counter and FSM are frozen; force_acq still acts.
- FSM ACQ:
  - valid, !hold, |in|<=LOCK_THR: counter increments.
  - valid, !hold, |in|>LOCK_THR: counter clears.
  - Counter reaches LOCK_CNT: go to TRK, counter cleared, locked=1 from the next cycle.
  - Invalid cycles neither advance nor clear the counter.
- FSM TRK:
  - valid, !hold, |in|>UNLOCK_THR: go to ACQ, locked=0 from the next cycle, counter=0.
- force_acq: go to ACQ, counter=0 next cycle. It takes priority over the lock transition in the same cycle; the sample is still processed with the current-state gains.
- |in| of the most negative input (-2^(IN_W-1)) is evaluated without overflow.

Decomposition:
- Shared package lf_pkg holds:
  - typedef enum {LF_ACQ, LF_TRK} lf_state_t
  - sat_signed / sat_unsigned clamp functions
  - abs function for the error input
- One sub-module, lf_lock_det: lock counter plus ACQ/TRK FSM. It outputs state and locked.
- The datapath stays in digital_lf_gear.

Test Plan:
- Reset, then in=+1 valid one cycle, then in=0 valid: out=4128, acc=16; next out=4097; out_valid pulses each time; locked=0.
- in=+7 valid continuously in ACQ: acc grows by 112 per sample up to 524287; out reaches 8191 with sat=1. Then in=-8 repeatedly: out leaves the clamp and sat drops.
- 16 consecutive valid in=0 samples with invalid gaps interleaved: locked=1 the cycle after the 16th. Next in=+1 gives out delta +8 (KP_TRK) and acc +2. A sample in=+5 gives locked=0 next cycle.
- 15 in=0 samples, one in=+2, then 15 in=0: still ACQ, because the counter cleared at in=+2.
- hold=1 with in=+3 valid in ACQ: acc unchanged and counter unchanged; out=INIT+96+(acc>>>4) each sample.
- force_acq while in TRK together with a valid in=0: that sample uses TRK gains, state is ACQ next cycle. Reset asserted mid-stream: all outputs return to reset values on the next edge.
